// File: rtl/pc_ras_unit_if.sv
// pc_ras_unit_if: fetch-stage control/address bundle between decode/hazard
// logic (master) and the program counter with return-address stack (slave).
//   master drives : stall, branch, call, ret, br_address
//   slave drives  : instr_address, return_address, ras_depth, ras_empty,
//                   ras_full, ras_overflow, ras_underflow
interface pc_ras_unit_if #(
  parameter int ADDR_W    = 10,
  parameter int RAS_DEPTH = 4
);
  localparam int DEPTH_W = $clog2(RAS_DEPTH) + 1;

  logic              stall;
  logic              branch;
  logic              call;
  logic              ret;
  logic [ADDR_W-1:0] br_address;
  logic [ADDR_W-1:0] instr_address;
  logic [ADDR_W-1:0] return_address;
  logic [DEPTH_W-1:0] ras_depth;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_overflow;
  logic              ras_underflow;

  modport master (
    output stall, branch, call, ret, br_address,
    input  instr_address, return_address, ras_depth,
    input  ras_empty, ras_full, ras_overflow, ras_underflow
  );

  modport slave (
    input  stall, branch, call, ret, br_address,
    output instr_address, return_address, ras_depth,
    output ras_empty, ras_full, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/pc_ras_unit.sv
// pc_ras_unit: parametrised fetch program counter with a circular
// return-address stack.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : pc_ras_unit_if.slave -- stall/branch/call/ret/br_address in,
//           instr_address (registered PC), return_address (PC+INC),
//           RAS depth/empty/full and sticky overflow/underflow out.
// Edge priority: stall > ret > call > branch > sequential.
module pc_ras_unit #(
  parameter int ADDR_W       = 10,
  parameter int INC          = 1,
  parameter int RESET_VECTOR = 0,
  parameter int RAS_DEPTH    = 4
) (
  input logic          clk,
  input logic          reset,
  pc_ras_unit_if.slave bus
);

  localparam int PTR_W   = $clog2(RAS_DEPTH);
  localparam int DEPTH_W = PTR_W + 1;

  localparam logic [ADDR_W-1:0]  INC_V   = ADDR_W'(INC);
  localparam logic [ADDR_W-1:0]  RST_V   = ADDR_W'(RESET_VECTOR);
  localparam logic [DEPTH_W-1:0] DEPTH_F = DEPTH_W'(RAS_DEPTH);

  logic [ADDR_W-1:0]  pc_q,    pc_d;
  logic [PTR_W-1:0]   top_q,   top_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               ovf_q,   ovf_d;
  logic               unf_q,   unf_d;
  logic [ADDR_W-1:0]  ras_q [RAS_DEPTH];

  logic               wr_en_s;
  logic [PTR_W-1:0]   wr_idx_s;
  logic [ADDR_W-1:0]  wr_data_s;
  logic [ADDR_W-1:0]  seq_pc_s;

  // Sequential successor; wraps naturally at the ADDR_W boundary.
  assign seq_pc_s = pc_q + INC_V;

  // Next-state selection following the stall > ret > call > branch priority.
  always_comb begin
    pc_d      = pc_q;
    top_d     = top_q;
    depth_d   = depth_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    wr_en_s   = 1'b0;
    wr_idx_s  = top_q + PTR_W'(1);
    wr_data_s = seq_pc_s;

    if (bus.stall) begin
      pc_d = pc_q;
    end else if (bus.ret) begin
      if (depth_q != DEPTH_W'(0)) begin
        pc_d    = ras_q[top_q];
        top_d   = top_q - PTR_W'(1);
        depth_d = depth_q - DEPTH_W'(1);
      end else begin
        pc_d  = seq_pc_s;
        unf_d = 1'b1;
      end
    end else if (bus.call) begin
      // The pointer always advances; when full, the slot it lands on holds
      // the oldest entry, which is simply overwritten.
      wr_en_s = 1'b1;
      top_d   = top_q + PTR_W'(1);
      pc_d    = bus.br_address;
      if (depth_q != DEPTH_F) begin
        depth_d = depth_q + DEPTH_W'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end else if (bus.branch) begin
      pc_d = bus.br_address;
    end else begin
      pc_d = seq_pc_s;
    end
  end

  // Control state: PC, stack pointer, depth and sticky flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RST_V;
      top_q   <= PTR_W'(0);
      depth_q <= DEPTH_W'(0);
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      top_q   <= top_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage; contents are meaningless while depth is 0, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      ras_q[wr_idx_s] <= wr_data_s;
    end else begin
      ras_q[wr_idx_s] <= ras_q[wr_idx_s];
    end
  end

  assign bus.instr_address  = pc_q;
  assign bus.return_address = seq_pc_s;
  assign bus.ras_depth      = depth_q;
  assign bus.ras_empty      = (depth_q == DEPTH_W'(0));
  assign bus.ras_full       = (depth_q == DEPTH_F);
  assign bus.ras_overflow   = ovf_q;
  assign bus.ras_underflow  = unf_q;

endmodule

// File: tb/tb_pc_ras_unit.sv
// Self-checking bench for pc_ras_unit: directed walk through the test plan
// followed by randomized control traffic, all checked against a queue-based
// reference model of the return-address stack.
module tb_pc_ras_unit;

  localparam int AW = 10;
  localparam int RD = 4;

  logic clk;
  logic reset;

  pc_ras_unit_if #(.ADDR_W(AW), .RAS_DEPTH(RD)) bus ();

  pc_ras_unit #(
    .ADDR_W(AW), .INC(1), .RESET_VECTOR(0), .RAS_DEPTH(RD)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: PC plus a queue of return addresses, newest at the back.
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_q[$];
  logic          m_ovf;
  logic          m_unf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = '0;
    m_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_step(input logic s, input logic b, input logic c,
                            input logic r, input logic [AW-1:0] a);
    if (s) begin
      // hold everything
    end else if (r) begin
      if (m_q.size() > 0) m_pc = m_q.pop_back();
      else begin
        m_pc  = m_pc + 10'd1;
        m_unf = 1'b1;
      end
    end else if (c) begin
      m_q.push_back(m_pc + 10'd1);
      if (m_q.size() > RD) begin
        void'(m_q.pop_front());
        m_ovf = 1'b1;
      end
      m_pc = a;
    end else if (b) begin
      m_pc = a;
    end else begin
      m_pc = m_pc + 10'd1;
    end
  endtask

  task automatic check_all(input string tag);
    logic [AW-1:0] exp_ret;
    exp_ret = m_pc + 10'd1;
    check({tag, ".pc"},    32'(bus.instr_address),  32'(m_pc));
    check({tag, ".retad"}, 32'(bus.return_address), 32'(exp_ret));
    check({tag, ".depth"}, 32'(bus.ras_depth),      32'(m_q.size()));
    check({tag, ".empty"}, 32'(bus.ras_empty),      32'(m_q.size() == 0));
    check({tag, ".full"},  32'(bus.ras_full),       32'(m_q.size() == RD));
    check({tag, ".ovf"},   32'(bus.ras_overflow),   32'(m_ovf));
    check({tag, ".unf"},   32'(bus.ras_underflow),  32'(m_unf));
  endtask

  task automatic step(input string tag, input logic s, input logic b, input logic c,
                      input logic r, input logic [AW-1:0] a);
    bus.stall      = s;
    bus.branch     = b;
    bus.call       = c;
    bus.ret        = r;
    bus.br_address = a;
    @(posedge clk);
    model_step(s, b, c, r, a);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // Assert reset between edges, check the asynchronous effect, release mid-cycle.
  task automatic do_reset(input string tag);
    bus.stall = 1'b0; bus.branch = 1'b0; bus.call = 1'b0; bus.ret = 1'b0;
    bus.br_address = '0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    repeat (2) @(posedge clk);
    #1 check_all({tag, ".hold"});
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic s, b, c, r;
    logic [AW-1:0] a;
    int pct;

    reset = 1'b0;
    model_reset();
    do_reset("rst0");

    // Sequential count after reset
    for (int i = 1; i <= 4; i++) begin
      idle("seq");
      check("seq.const", 32'(bus.instr_address), 32'(i));
    end

    // Branch / stall (restart at PC 2 to match the plan)
    do_reset("rst1");
    idle("s1"); idle("s2");
    step("br3", 1'b0, 1'b1, 1'b0, 1'b0, 10'd3);
    check("br3.const", 32'(bus.instr_address), 32'd3);
    idle("s4"); idle("s5");
    repeat (3) step("stall", 1'b1, 1'b0, 1'b0, 1'b0, '0);
    check("stall.const", 32'(bus.instr_address), 32'd5);
    idle("s6");
    repeat (2) step("stbr", 1'b1, 1'b1, 1'b0, 1'b0, 10'd2);
    check("stbr.const", 32'(bus.instr_address), 32'd6);
    step("brrel", 1'b0, 1'b1, 1'b0, 1'b0, 10'd2);
    check("brrel.const", 32'(bus.instr_address), 32'd2);
    idle("s3"); idle("s4"); idle("s5");

    // Call / return
    step("call", 1'b0, 1'b0, 1'b1, 1'b0, 10'h100);
    check("call.pc",   32'(bus.instr_address),  32'h100);
    check("call.ra",   32'(bus.return_address), 32'h101);
    check("call.dep",  32'(bus.ras_depth),      32'd1);
    idle("c1"); idle("c2");
    step("ret", 1'b0, 1'b0, 1'b0, 1'b1, '0);
    check("ret.const", 32'(bus.instr_address), 32'd6);
    step("callret", 1'b0, 1'b1, 1'b1, 1'b1, 10'h050);
    check("callret.pc",  32'(bus.instr_address), 32'd7);
    check("callret.unf", 32'(bus.ras_underflow), 32'd1);

    // Overflow / underflow
    do_reset("rst2");
    step("to10", 1'b0, 1'b1, 1'b0, 1'b0, 10'd10);
    for (int i = 2; i <= 6; i++) begin
      step("nest", 1'b0, 1'b0, 1'b1, 1'b0, 10'(i * 10));
      if (i == 5) check("nest.full", 32'(bus.ras_full), 32'd1);
    end
    check("nest.ovf", 32'(bus.ras_overflow), 32'd1);
    for (int i = 5; i >= 2; i--) begin
      step("unwind", 1'b0, 1'b0, 1'b0, 1'b1, '0);
      check("unwind.const", 32'(bus.instr_address), 32'(i * 10 + 1));
    end
    step("ret5", 1'b0, 1'b0, 1'b0, 1'b1, '0);
    check("ret5.pc",  32'(bus.instr_address), 32'd22);
    check("ret5.unf", 32'(bus.ras_underflow), 32'd1);
    check("ret5.emp", 32'(bus.ras_empty),     32'd1);

    // Wrap at the top of the address space
    step("b1023", 1'b0, 1'b1, 1'b0, 1'b0, 10'd1023);
    idle("wrap");
    check("wrap.const", 32'(bus.instr_address), 32'd0);
    step("b1023b", 1'b0, 1'b1, 1'b0, 1'b0, 10'd1023);
    check("wrap.ra", 32'(bus.return_address), 32'd0);
    step("callw", 1'b0, 1'b0, 1'b1, 1'b0, 10'd5);
    step("retw",  1'b0, 1'b0, 1'b0, 1'b1, '0);
    check("retw.const", 32'(bus.instr_address), 32'd0);

    // Async reset mid-operation with depth 2 at PC 0x200
    step("m1", 1'b0, 1'b0, 1'b1, 1'b0, 10'h300);
    step("m2", 1'b0, 1'b0, 1'b1, 1'b0, 10'h200);
    check("mid.dep", 32'(bus.ras_depth), 32'd2);
    do_reset("rstmid");
    check("rstmid.pc", 32'(bus.instr_address), 32'd0);
    idle("after");
    check("after.const", 32'(bus.instr_address), 32'd1);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      pct = int'($urandom_range(0, 99));
      s = (pct < 12);
      r = ($urandom_range(0, 99) < 25);
      c = ($urandom_range(0, 99) < 30);
      b = ($urandom_range(0, 99) < 20);
      a = 10'($urandom);
      if (n % 10 == 0 && $urandom_range(0, 9) == 0) a = 10'd1023;
      step("rnd", s, b, c, r, a);
      if (n == 300) do_reset("rndrst");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pc_ras_unit.md
Name: pc_ras_unit

Overview:
Parametrised program counter for the fetch stage, generalising the fixed 10-bit PC. It adds a configurable address width, a configurable sequential increment and reset vector, and a circular return-address stack (RAS) that handles call/return flow. It drives the instruction-memory address and accepts branch/call/return/stall controls from decode and the hazard unit.

Parameters:
ADDR_W, 10, width of the PC, branch target and RAS entries
INC, 1, sequential increment added to the PC each advancing cycle
RESET_VECTOR, 0, PC value loaded on reset
RAS_DEPTH, 4, number of return-address stack entries (power of two, >=2)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
stall  input  1  hold PC and RAS this cycle
branch  input  1  jump to br_address
call  input  1  push return address, jump to br_address
ret  input  1  pop RAS top into PC
br_address  input  ADDR_W  branch/call target
instr_address  output  ADDR_W  registered current PC
return_address  output  ADDR_W  combinational instr_address+INC, mod 2^ADDR_W
ras_depth  output  clog2(RAS_DEPTH)+1  valid entries, 0..RAS_DEPTH
ras_empty  output  1  ras_depth==0
ras_full  output  1  ras_depth==RAS_DEPTH
ras_overflow  output  1  sticky: a call overwrote the oldest entry
ras_underflow  output  1  sticky: ret issued on an empty stack

Behaviour:
- Reset (async, any time, including mid-operation): instr_address=RESET_VECTOR, ras_depth=0, top pointer=0, both sticky flags=0. Entry contents are don't-care. Outputs change immediately, with no clock edge needed.
- All state updates on the rising clk edge; one-cycle latency from control inputs to instr_address.
- Per-edge priority, first match wins:
  1 stall: PC, RAS and flags hold. branch/call/ret are ignored and not queued.
  2 ret: if depth>0, PC<=RAS[top], top decrements (mod RAS_DEPTH), depth decrements. If depth==0, PC<=PC+INC and ras_underflow<=1. A coincident call/branch is ignored.
  3 call: RAS[top+1]<=PC+INC, top increments, PC<=br_address. If depth<RAS_DEPTH, depth increments. Otherwise depth stays at RAS_DEPTH, the oldest entry is overwritten (circular) and ras_overflow<=1. A coincident branch is ignored.
  4 branch: PC<=br_address; RAS unchanged.
  5 none: PC<=PC+INC.
- Arithmetic is unsigned, modulo 2^ADDR_W. (2^ADDR_W-1)+1 wraps to 0, with no flag.
- Sticky flags clear only on reset.
- return_address is purely combinational from instr_address.
- No X propagation: controls are sampled as 0 when reset deasserts.

Test Plan:
- Reset/sequential: defaults, reset high for 2 cycles then low. Expect instr_address 0 during reset, then 1,2,3,4 on successive edges. All RAS outputs show empty, depth 0 and flags 0.
- Branch/stall: branch=1, br_address=3 at PC=2, giving 3 and then 4. Stall for 3 cycles at PC=5 holds 5,5,5 and resumes at 6. Stall with branch=1, br_address=2 held high stays at 6; stall releases, then PC=2.
- Call/return: at PC=5, call with br_address=0x100, giving PC 0x100, depth 1, return_address showing 0x101. Advance to 0x102, then ret gives PC 6 and depth 0. call+ret together on an empty stack gives PC+1 and underflow=1, with no push.
- Overflow/underflow: 5 nested calls from PCs 10,20,30,40,50 (targets chaining). Expect ras_full after the 4th call, and overflow=1 after the 5th. 4 rets yield 51,41,31,21. A 5th ret gives PC+1, underflow=1, ras_empty=1.
- Wrap: branch to 1023, then next edge gives 0. A call at 1023 pushes 0 and ret returns PC 0.
- Async reset mid-operation: with depth 2 and PC=0x200, assert reset between clock edges. instr_address=0, depth 0 and flags clear before the next edge. After release, sequential count restarts from 1.
